threewire_slave_ctrl: RTL

Three-wire bus responder: the slave-side endpoint of the three-wire protocol driven by the team's three-wire master. Oversamples the bus clock, chip select and data line in the `in_clk` domain and deserialises the R/W flag and the address. It then either captures write data and issues a write strobe, or requests read data and shifts it back onto the shared data line. It sits between the board-level three-wire pins and a local register file.

---
 rtl/threewire_pkg.sv | 35 +++
 rtl/threewire_sync_edge.sv | 48 ++++
 rtl/threewire_slave_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/threewire_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | threewire_pkg - three-wire bus state encoding and R/W flag, shared with    |
// |                 the three-wire master.                                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package threewire_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RW      = 3'd1;
    localparam logic [2:0] ADDR    = 3'd2;
    localparam logic [2:0] WR_DATA = 3'd3;
    localparam logic [2:0] TURN    = 3'd4;
    localparam logic [2:0] RD_DATA = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE    = IDLE,
        S_RW      = RW,
        S_ADDR    = ADDR,
        S_WR_DATA = WR_DATA,
        S_TURN    = TURN,
        S_RD_DATA = RD_DATA,
        S_DONE    = DONE
    } tw_state_e;

    localparam logic c_RW_WRITE = 1'b1;

    function automatic int tw_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/threewire_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | threewire_sync_edge - 2-FF synchronizer with registered rise/fall pulses.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module threewire_sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic in_clk,
    input  logic in_rst,
    input  logic in_d,
    output logic out_level,
    output logic out_rise,
    output logic out_fall
);

    logic meta_q, sync_q, prev_q, rise_q, fall_q;
    logic rise_d, fall_d;

    always_comb begin
        rise_d = sync_q & ~prev_q;
        fall_d = ~sync_q & prev_q;
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= in_d;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // prev_q changes in the same cycle the edge pulse is seen, so level and event line up
    assign out_level = prev_q;
    assign out_rise  = rise_q;
    assign out_fall  = fall_q;

endmodule
`default_nettype wire

// File: rtl/threewire_slave_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | threewire_slave_ctrl - three-wire bus responder feeding a register file.   |
// | Option: THREEWIRE_SLAVE_ADDR_MATCH_EN serves only matching addresses.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module threewire_slave_ctrl
    import threewire_pkg::*;
#(
    parameter int                          TWS_ADDRESS_BITS = 10,
    parameter int                          TWS_DATA_BITS    = 32,
    parameter logic [TWS_ADDRESS_BITS-1:0] TWS_ADDR_MATCH   = '0,
    parameter logic [TWS_ADDRESS_BITS-1:0] TWS_ADDR_MASK    = '0
) (
    input  logic                        in_clk,
    input  logic                        in_rst,
    input  logic                        in_tw_clock,
    input  logic                        in_tw_cs,
    inout  wire                         io_tw_data,
    output logic                        out_tw_oe,
    output logic [TWS_ADDRESS_BITS-1:0] out_addr,
    output logic [TWS_DATA_BITS-1:0]    out_wr_data,
    output logic                        out_wr_strobe,
    output logic                        out_rd_req,
    input  logic [TWS_DATA_BITS-1:0]    in_rd_data,
    output logic                        out_busy,
    output logic                        out_abort
);

    localparam int c_CNT_W = $clog2(tw_max(tw_max(TWS_ADDRESS_BITS, TWS_DATA_BITS), 2));
`ifdef THREEWIRE_SLAVE_ADDR_MATCH_EN
    localparam bit c_MATCH_EN = 1'b1;
`else
    localparam bit c_MATCH_EN = 1'b0;
`endif

    logic w_clk_rise, w_clk_level_unused, w_clk_fall_unused;
    logic w_cs_level, w_cs_fall, w_cs_rise_unused;
    logic w_data_level, w_data_rise_unused, w_data_fall_unused;

    threewire_sync_edge #(.RESET_VAL(1'b1)) u_sync_clk (
        .in_clk(in_clk), .in_rst(in_rst), .in_d(in_tw_clock),
        .out_level(w_clk_level_unused), .out_rise(w_clk_rise), .out_fall(w_clk_fall_unused)
    );

    threewire_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
        .in_clk(in_clk), .in_rst(in_rst), .in_d(in_tw_cs),
        .out_level(w_cs_level), .out_rise(w_cs_rise_unused), .out_fall(w_cs_fall)
    );

    threewire_sync_edge #(.RESET_VAL(1'b1)) u_sync_data (
        .in_clk(in_clk), .in_rst(in_rst), .in_d(io_tw_data),
        .out_level(w_data_level), .out_rise(w_data_rise_unused), .out_fall(w_data_fall_unused)
    );

    tw_state_e                     state_q, state_d;
    logic [c_CNT_W-1:0]            cnt_q, cnt_d;
    logic                          rw_q, rw_d;
    logic                          match_q, match_d;
    logic [TWS_ADDRESS_BITS-2:0]   addr_sh_q, addr_sh_d;
    logic [TWS_DATA_BITS-2:0]      data_sh_q, data_sh_d;
    logic [TWS_DATA_BITS-1:0]      tx_sh_q, tx_sh_d;
    logic [TWS_ADDRESS_BITS-1:0]   addr_q, addr_d;
    logic [TWS_DATA_BITS-1:0]      wr_data_q, wr_data_d;
    logic                          oe_q, oe_d;
    logic                          wr_strobe_q, wr_strobe_d;
    logic                          rd_req_q, rd_req_d;
    logic                          abort_q, abort_d;

    logic [TWS_ADDRESS_BITS-1:0]   w_addr_next;
    logic [TWS_DATA_BITS-1:0]      w_data_next;
    logic                          w_addr_match;
    logic                          w_cnt_zero;

    assign w_addr_next  = {addr_sh_q, w_data_level};
    assign w_data_next  = {data_sh_q, w_data_level};
    assign w_cnt_zero   = (cnt_q == '0);
    assign w_addr_match = !c_MATCH_EN ||
                          ((w_addr_next & TWS_ADDR_MASK) == (TWS_ADDR_MATCH & TWS_ADDR_MASK));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rw_d        = rw_q;
        match_d     = match_q;
        addr_sh_d   = addr_sh_q;
        data_sh_d   = data_sh_q;
        tx_sh_d     = tx_sh_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        oe_d        = oe_q;
        wr_strobe_d = 1'b0;
        rd_req_d    = 1'b0;
        abort_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_cs_fall) state_d = S_RW;
            end
            S_DONE: begin
                if (w_cs_level) state_d = S_IDLE;
            end
            default: begin
                if (w_cs_level) begin
                    state_d = S_IDLE;
                    oe_d    = 1'b0;
                    abort_d = 1'b1;
                end else if (w_clk_rise) begin
                    case (state_q)
                        S_RW: begin
                            rw_d    = w_data_level;
                            cnt_d   = c_CNT_W'(TWS_ADDRESS_BITS - 1);
                            state_d = S_ADDR;
                        end
                        S_ADDR: begin
                            addr_sh_d = w_addr_next[TWS_ADDRESS_BITS-2:0];
                            if (w_cnt_zero) begin
                                addr_d  = w_addr_next;
                                match_d = w_addr_match;
                                cnt_d   = c_CNT_W'(TWS_DATA_BITS - 1);
                                if (rw_q == c_RW_WRITE) begin
                                    state_d = S_WR_DATA;
                                end else begin
                                    state_d  = S_TURN;
                                    rd_req_d = w_addr_match;
                                end
                            end else begin
                                cnt_d = cnt_q - c_CNT_W'(1);
                            end
                        end
                        S_WR_DATA: begin
                            data_sh_d = w_data_next[TWS_DATA_BITS-2:0];
                            if (w_cnt_zero) begin
                                if (match_q) begin
                                    wr_data_d   = w_data_next;
                                    wr_strobe_d = 1'b1;
                                end
                                state_d = S_DONE;
                            end else begin
                                cnt_d = cnt_q - c_CNT_W'(1);
                            end
                        end
                        S_TURN: begin
                            tx_sh_d = in_rd_data;
                            oe_d    = match_q;
                            state_d = S_RD_DATA;
                        end
                        S_RD_DATA: begin
                            // counter reaches zero with the LSB on the line; next edge releases it
                            if (w_cnt_zero) begin
                                oe_d    = 1'b0;
                                state_d = S_DONE;
                            end else begin
                                tx_sh_d = {tx_sh_q[TWS_DATA_BITS-2:0], 1'b0};
                                cnt_d   = cnt_q - c_CNT_W'(1);
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rw_q        <= 1'b0;
            match_q     <= 1'b0;
            addr_sh_q   <= '0;
            data_sh_q   <= '0;
            tx_sh_q     <= '0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            oe_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
            rd_req_q    <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            match_q     <= match_d;
            addr_sh_q   <= addr_sh_d;
            data_sh_q   <= data_sh_d;
            tx_sh_q     <= tx_sh_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            oe_q        <= oe_d;
            wr_strobe_q <= wr_strobe_d;
            rd_req_q    <= rd_req_d;
            abort_q     <= abort_d;
        end
    end

    assign io_tw_data    = oe_q ? tx_sh_q[TWS_DATA_BITS-1] : 1'bz;
    assign out_tw_oe     = oe_q;
    assign out_addr      = addr_q;
    assign out_wr_data   = wr_data_q;
    assign out_wr_strobe = wr_strobe_q;
    assign out_rd_req    = rd_req_q;
    assign out_abort     = abort_q;
    assign out_busy      = (state_q != S_IDLE) || w_cs_fall;

endmodule
`default_nettype wire
